// File: rtl/b12_seq_pkg.sv
// Shared types and opcode layout for the b12 stimulus sequencer.
package b12_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Opcode layout: {obs, k[3:0], start}
    localparam int unsigned OP_W       = 6;
    localparam int unsigned OBS_B      = 5;
    localparam int unsigned K_MSB      = 4;
    localparam int unsigned K_LSB      = 1;
    localparam int unsigned START_B    = 0;

    localparam int unsigned PC_TRACE_W = 6;
    localparam int unsigned TRACE_W    = 12;
    localparam int unsigned SPK_W      = 16;

endpackage

// File: rtl/b12_seq_ram.sv
// Program store: DEPTH opcodes, synchronous write, combinational read, no reset.
module b12_seq_ram
    import b12_seq_pkg::*;
#(
    parameter int unsigned DEPTH  = 6,
    parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [OP_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [OP_W-1:0]   rd_data
);

    logic [OP_W-1:0] mem [DEPTH];

    // Write port; callers guarantee wr_addr < DEPTH when we is high.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/b12_stim_sequencer.sv
// Plays a stored opcode program onto b12's inputs and traces b12's responses.
module b12_stim_sequencer
    import b12_seq_pkg::*;
#(
    parameter int unsigned DEPTH  = 6,
    parameter int unsigned HOLD   = 1,
    parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ld_en,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [OP_W-1:0]    ld_data,
    output logic               ld_err,
    input  logic               go,
    input  logic               pause,
    input  logic               abort,
    input  logic [ADDR_W:0]    len,
    input  logic               loop_en,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  pc,
    output logic [3:0]         k,
    output logic               start,
    output logic               obs,
    input  logic               dut_nloss,
    input  logic [3:0]         dut_nl,
    input  logic               dut_speaker,
    output logic               trace_vld,
    output logic [TRACE_W-1:0] trace_data,
    output logic [SPK_W-1:0]   spk_cnt
);

    localparam int unsigned HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD - 1);
    localparam int unsigned LEN_W     = ADDR_W + 1;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [OP_W-1:0]      op_q, op_d;
    logic                 done_q, done_d;
    logic                 busy_q;
    logic                 ld_err_q;
    logic                 trace_vld_q, trace_vld_d;
    logic [TRACE_W-1:0]   trace_data_q, trace_data_d;
    logic [SPK_W-1:0]     spk_cnt_q;
    logic                 spk_prev_q;
    logic                 spk_clr;

    logic                 hold_zero;
    logic                 last_step;
    logic [LEN_W-1:0]     len_clamp;
    logic                 ram_we;
    logic                 addr_ok;
    logic [ADDR_W-1:0]    rd_addr;
    logic [OP_W-1:0]      rd_data;

    assign hold_zero = (hold_q == '0);
    assign last_step = (LEN_W'(pc_q) == (len_q - LEN_W'(1)));
    assign len_clamp = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
    assign addr_ok   = (LEN_W'(ld_addr) < LEN_W'(DEPTH));
    assign ram_we    = ld_en && !busy_q && addr_ok;

    // The opcode that becomes current next: pc+1 on a normal step, else slot 0.
    assign rd_addr = (state_q == RUN && !last_step) ? (pc_q + ADDR_W'(1)) : '0;

    b12_seq_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock   (clock),
        .we      (ram_we),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything, pause beats a step end.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (go) begin
                        state_d = (len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (hold_zero && last_step && !loop_en) begin
                        state_d = DONE;
                    end
                end
                PAUSE: begin
                    if (!pause) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next values: pc, hold counter, driven opcode, pulses and trace.
    always_comb begin
        pc_d         = pc_q;
        hold_d       = hold_q;
        len_d        = len_q;
        op_d         = op_q;
        done_d       = 1'b0;
        trace_vld_d  = 1'b0;
        trace_data_d = trace_data_q;
        spk_clr      = 1'b0;
        if (abort) begin
            pc_d   = '0;
            hold_d = '0;
            op_d   = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    op_d = '0;
                    if (go) begin
                        if (len == '0) begin
                            done_d = 1'b1;
                        end else begin
                            pc_d    = '0;
                            hold_d  = HOLD_INIT;
                            len_d   = len_clamp;
                            op_d    = rd_data;
                            spk_clr = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!pause) begin
                        if (!hold_zero) begin
                            hold_d = hold_q - HOLD_W'(1);
                        end else begin
                            trace_vld_d  = 1'b1;
                            trace_data_d = {PC_TRACE_W'(pc_q), dut_nloss, dut_nl, dut_speaker};
                            if (!last_step) begin
                                pc_d   = pc_q + ADDR_W'(1);
                                hold_d = HOLD_INIT;
                                op_d   = rd_data;
                            end else if (loop_en) begin
                                pc_d   = '0;
                                hold_d = HOLD_INIT;
                                op_d   = rd_data;
                            end else begin
                                op_d   = '0;
                                done_d = 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered datapath and status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q         <= '0;
            hold_q       <= '0;
            len_q        <= '0;
            op_q         <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            ld_err_q     <= 1'b0;
            trace_vld_q  <= 1'b0;
            trace_data_q <= '0;
        end else begin
            pc_q         <= pc_d;
            hold_q       <= hold_d;
            len_q        <= len_d;
            op_q         <= op_d;
            done_q       <= done_d;
            busy_q       <= (state_d == RUN) || (state_d == PAUSE);
            ld_err_q     <= ld_en && (busy_q || !addr_ok);
            trace_vld_q  <= trace_vld_d;
            trace_data_q <= trace_data_d;
        end
    end

    // Saturating count of speaker rising edges seen while playing.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            spk_prev_q <= 1'b0;
            spk_cnt_q  <= '0;
        end else begin
            spk_prev_q <= dut_speaker;
            if (spk_clr) begin
                spk_cnt_q <= '0;
            end else if (busy_q && dut_speaker && !spk_prev_q && (spk_cnt_q != '1)) begin
                spk_cnt_q <= spk_cnt_q + SPK_W'(1);
            end
        end
    end

    assign ld_err     = ld_err_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pc         = pc_q;
    assign k          = op_q[K_MSB:K_LSB];
    assign start      = op_q[START_B];
    assign obs        = op_q[OBS_B];
    assign trace_vld  = trace_vld_q;
    assign trace_data = trace_data_q;
    assign spk_cnt    = spk_cnt_q;

endmodule

// File: tb/tb_b12_stim_sequencer.sv
// Directed bench for b12_stim_sequencer: HOLD=1 instance plus a HOLD=3 instance on shared inputs.
module tb_b12_stim_sequencer;
    import b12_seq_pkg::*;

    localparam int unsigned DEPTH  = 6;
    localparam int unsigned ADDR_W = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [5:0]        ld_data;
    logic              go, pause, abort, loop_en;
    logic [ADDR_W:0]   len;
    logic              dut_nloss, dut_speaker;
    logic [3:0]        dut_nl;

    logic              ld_err, busy, done, start, obs, trace_vld;
    logic [ADDR_W-1:0] pc;
    logic [3:0]        k;
    logic [11:0]       trace_data;
    logic [15:0]       spk_cnt;

    logic              ld_err_3, busy_3, done_3, start_3, obs_3, trace_vld_3;
    logic [ADDR_W-1:0] pc_3;
    logic [3:0]        k_3;
    logic [11:0]       trace_data_3;
    logic [15:0]       spk_cnt_3;

    logic [5:0]        op_seen, op_seen_3;
    assign op_seen   = {obs, k, start};
    assign op_seen_3 = {obs_3, k_3, start_3};

    int checks = 0;
    int errors = 0;

    b12_stim_sequencer #(.DEPTH(DEPTH), .HOLD(1)) u_dut (
        .clock(clock), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_err(ld_err), .go(go), .pause(pause), .abort(abort), .len(len), .loop_en(loop_en),
        .busy(busy), .done(done), .pc(pc), .k(k), .start(start), .obs(obs),
        .dut_nloss(dut_nloss), .dut_nl(dut_nl), .dut_speaker(dut_speaker),
        .trace_vld(trace_vld), .trace_data(trace_data), .spk_cnt(spk_cnt)
    );

    b12_stim_sequencer #(.DEPTH(DEPTH), .HOLD(3)) u_dut3 (
        .clock(clock), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_err(ld_err_3), .go(go), .pause(pause), .abort(abort), .len(len), .loop_en(loop_en),
        .busy(busy_3), .done(done_3), .pc(pc_3), .k(k_3), .start(start_3), .obs(obs_3),
        .dut_nloss(dut_nloss), .dut_nl(dut_nl), .dut_speaker(dut_speaker),
        .trace_vld(trace_vld_3), .trace_data(trace_data_3), .spk_cnt(spk_cnt_3)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        go;
        logic        nloss;
        logic [3:0]  nl;
        logic        spk;
        logic [5:0]  e_op;
        logic [2:0]  e_pc;
        logic        c_pc;
        logic        e_busy;
        logic        e_done;
        logic        e_tv;
        logic [11:0] e_td;
        logic [15:0] e_spk;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic load(input logic [2:0] a, input logic [5:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic got;
        ld_en = 0; ld_addr = '0; ld_data = '0; go = 0; pause = 0; abort = 0;
        loop_en = 0; len = '0; dut_nloss = 0; dut_nl = '0; dut_speaker = 0;

        //                go    nl   nl    spk  op     pc    cpc   busy  done  tv    td       spk
        vecs[0] = '{1'b1, 1'b0, 4'h0, 1'b0, 6'h01, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 16'd0};
        vecs[1] = '{1'b0, 1'b1, 4'h3, 1'b0, 6'h1E, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h026, 16'd0};
        vecs[2] = '{1'b0, 1'b0, 4'h5, 1'b1, 6'h20, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 12'h04B, 16'd1};
        vecs[3] = '{1'b0, 1'b1, 4'hA, 1'b0, 6'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0B4, 16'd1};
        vecs[4] = '{1'b0, 1'b0, 4'h0, 1'b0, 6'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0B4, 16'd1};

        // Reset and reset-state checks
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("rst_op", 32'(op_seen), 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ld_err", 32'(ld_err), 32'h0);
        chk("rst_tv", 32'(trace_vld), 32'h0);
        chk("rst_td", 32'(trace_data), 32'h0);
        chk("rst_spk", 32'(spk_cnt), 32'h0);

        // Program load
        load(3'd0, 6'h01); load(3'd1, 6'h1E); load(3'd2, 6'h20);
        load(3'd3, 6'h2A); load(3'd4, 6'h15); load(3'd5, 6'h3F);
        chk("load_ld_err", 32'(ld_err), 32'h0);

        // Basic playback, HOLD=1, len=3
        len = 4'd3; loop_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            go = vecs[i].go; dut_nloss = vecs[i].nloss; dut_nl = vecs[i].nl; dut_speaker = vecs[i].spk;
            tick();
            chk($sformatf("v%0d_op", i), 32'(op_seen), 32'(vecs[i].e_op));
            if (vecs[i].c_pc) chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].e_pc));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].e_done));
            chk($sformatf("v%0d_tv", i), 32'(trace_vld), 32'(vecs[i].e_tv));
            if (vecs[i].e_tv) chk($sformatf("v%0d_td", i), 32'(trace_data), 32'(vecs[i].e_td));
            chk($sformatf("v%0d_spk", i), 32'(spk_cnt), 32'(vecs[i].e_spk));
        end
        go = 0; dut_nloss = 0; dut_nl = '0; dut_speaker = 0;

        // HOLD=3 instance, len=2: op0 cycles 1-3, op1 cycles 4-6, done cycle 7
        do_abort();
        len = 4'd2; go = 1'b1;
        tick();
        go = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c <= 6) begin
                chk($sformatf("h3_c%0d_pc", c), 32'(pc_3), (c <= 3) ? 32'd0 : 32'd1);
                chk($sformatf("h3_c%0d_op", c), 32'(op_seen_3), (c <= 3) ? 32'h01 : 32'h1E);
                chk($sformatf("h3_c%0d_busy", c), 32'(busy_3), 32'd1);
                chk($sformatf("h3_c%0d_done", c), 32'(done_3), 32'd0);
            end else begin
                chk("h3_c7_done", 32'(done_3), 32'd1);
                chk("h3_c7_busy", 32'(busy_3), 32'd0);
                chk("h3_c7_op", 32'(op_seen_3), 32'h00);
            end
            tick();
        end

        // Looping: pc alternates, no done; clearing loop_en lets it finish
        do_abort();
        len = 4'd2; loop_en = 1'b1; go = 1'b1;
        tick();
        go = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            chk($sformatf("loop_c%0d_pc", c), 32'(pc), 32'((c - 1) % 2));
            chk($sformatf("loop_c%0d_done", c), 32'(done), 32'd0);
            tick();
        end
        loop_en = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            tick();
            if (done) got = 1'b1;
        end
        chk("loop_exit_done", 32'(got), 32'd1);

        // Pause during step 1 for 5 cycles
        do_abort();
        len = 4'd3; go = 1'b1;
        tick();
        go = 1'b0;
        chk("pause_c1_pc", 32'(pc), 32'd0);
        tick();
        chk("pause_c2_pc", 32'(pc), 32'd1);
        pause = 1'b1;
        for (int c = 3; c <= 6; c++) begin
            tick();
            chk($sformatf("pause_c%0d_pc", c), 32'(pc), 32'd1);
            chk($sformatf("pause_c%0d_op", c), 32'(op_seen), 32'h1E);
            chk($sformatf("pause_c%0d_tv", c), 32'(trace_vld), 32'd0);
            chk($sformatf("pause_c%0d_busy", c), 32'(busy), 32'd1);
        end
        pause = 1'b0;
        tick();
        chk("resume_c7_pc", 32'(pc), 32'd1);
        chk("resume_c7_tv", 32'(trace_vld), 32'd0);
        tick();
        chk("resume_c8_pc", 32'(pc), 32'd2);
        chk("resume_c8_op", 32'(op_seen), 32'h20);
        chk("resume_c8_tv", 32'(trace_vld), 32'd1);
        chk("resume_c8_tpc", 32'(trace_data[11:6]), 32'd1);

        // Rejected writes: while busy, and out-of-range address while idle
        do_abort();
        len = 4'd3; go = 1'b1;
        tick();
        go = 1'b0;
        load(3'd0, 6'h3F);
        chk("ld_busy_err", 32'(ld_err), 32'd1);
        tick();
        chk("ld_err_clear", 32'(ld_err), 32'd0);
        do_abort();
        load(3'd6, 6'h3F);
        chk("ld_range_err", 32'(ld_err), 32'd1);
        len = 4'd3; go = 1'b1;
        tick();
        go = 1'b0;
        chk("rb_op0", 32'(op_seen), 32'h01);
        tick();
        chk("rb_op1", 32'(op_seen), 32'h1E);
        tick();
        chk("rb_op2", 32'(op_seen), 32'h20);

        // go with len=0: straight to DONE
        do_abort();
        len = 4'd0; go = 1'b1;
        tick();
        go = 1'b0;
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        chk("len0_op", 32'(op_seen), 32'h00);
        tick();
        chk("len0_done_pulse", 32'(done), 32'd0);

        // len above DEPTH clamps to 6 steps: done on cycle 7
        len = 4'd15; go = 1'b1;
        tick();
        go = 1'b0;
        cyc = 1;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("clamp_done_cycle", 32'(cyc), 32'd7);

        // Abort mid-run: outputs cleared next cycle, speaker count kept
        do_abort();
        len = 4'd3; go = 1'b1;
        tick();
        go = 1'b0; dut_speaker = 1'b1;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0; dut_speaker = 1'b0;
        chk("abort_op", 32'(op_seen), 32'h00);
        chk("abort_pc", 32'(pc), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_tv", 32'(trace_vld), 32'd0);
        chk("abort_spk", 32'(spk_cnt), 32'd1);

        // Async reset mid-run: immediate clear, no done afterwards
        len = 4'd3; go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        #2 reset = 1'b0;
        #1;
        chk("arst_op", 32'(op_seen), 32'h00);
        chk("arst_pc", 32'(pc), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_tv", 32'(trace_vld), 32'd0);
        chk("arst_spk", 32'(spk_cnt), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("arst_post_done", 32'(done), 32'd0);
        chk("arst_post_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
